axi_lite_write_ctrl: RTL and testbench
======================================

# axi_lite_write_ctrl

AXI4-Lite write-channel controller for the register block. It accepts independent AW and W handshakes in either order and decodes the captured address into a word offset. It issues a single-cycle strobed write to the register file and returns the B response. It sits between the AXI slave port and the register array, directly downstream of the address decode stage.

## Interface
Parameters:
- BaseAddr, 32'h0000_0000: base of the register window; must be aligned to 2^(OffsetWidth+2).
- OffsetWidth, 6: word-offset width; the window holds 2^OffsetWidth 32-bit registers.

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- awvalid  in  1  write-address valid.
- awready  out  1  write-address ready.
- awaddr  in  32  write address.
- wvalid  in  1  write-data valid.
- wready  out  1  write-data ready.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- bvalid  out  1  response valid.
- bready  in  1  response ready.
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- reg_we  out  1  register-file write enable, one-cycle pulse.
- reg_waddr  out  OffsetWidth  word offset of the write.
- reg_wdata  out  32  write data.
- reg_wstrb  out  4  byte strobes to the register file.

## Operation
The controller is a state machine with five states:
- IDLE
  - awready=1, wready=1.
  - AW only → latch addr → WAIT_W.
  - W only → latch data/strb → WAIT_A.
  - Both in the same cycle → latch both → WRITE.
- WAIT_W
  - awready=0, wready=1.
  - W handshake → WRITE.
- WAIT_A
  - awready=1, wready=0.
  - AW handshake → WRITE.
- WRITE (exactly one cycle)
  - reg_we=1 only if the address is valid.
  - bresp is registered as OKAY when valid, otherwise SLVERR.
  - → RESP.
- RESP
  - bvalid=1, bresp held stable.
  - bvalid&bready → IDLE.

Address validity:
- A valid address means out_of_range=0 and byte_offset=2'b00.
- A misaligned or out-of-window address gives SLVERR and no register write.

Handshake rules:
- Only one transaction is outstanding. No AW or W is accepted from WRITE or RESP.
- The ready outputs are pure functions of state. They never depend on valid inputs.
- wstrb=4'b0000 on a valid address gives reg_we=1 with reg_wstrb=0 and an OKAY response; the register file writes nothing.
- awaddr, wdata and wstrb are captured only on their own handshake. reg_waddr, reg_wdata and reg_wstrb come from those registers and are stable throughout WRITE.

Reset:
- State goes to IDLE.
- bvalid=0, reg_we=0, bresp=2'b00.
- Latched addr/data/strb are cleared to 0.
- awready=wready=1 from the first cycle after reset deasserts.
- Reset mid-transaction drops the transaction. No reg_we and no bvalid follow.

## Timing
- Last of AW/W handshakes in cycle N → reg_we in N+1 → bvalid from N+2.
- bvalid&bready in cycle M → IDLE in M+1 → next AW/W is accepted in M+1 at the earliest.
- Minimum spacing between back-to-back writes is 3 cycles when bready is held at 1.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package axi_reg_pkg holds:
  - the state enum (IDLE, WAIT_W, WAIT_A, WRITE, RESP);
  - constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- The read-channel controller reuses this package.
- Instantiate the existing addr_decoder as the one sub-module, with BaseAddr/OffsetWidth passed through. It is fed from the latched address register.

## Test plan
- AW and W in the same cycle, awaddr=BaseAddr+0x0C, wdata=0xDEADBEEF, wstrb=4'hF:
  - reg_we in cycle N+1 with reg_waddr=3 and reg_wdata=0xDEADBEEF;
  - bvalid at N+2 with bresp=OKAY.
- W first, AW 3 cycles later (awaddr=BaseAddr+0x04, wstrb=4'b0101):
  - wready=0 while waiting;
  - write with reg_waddr=1 and reg_wstrb=4'b0101; OKAY.
- awaddr=BaseAddr+2^(OffsetWidth+2) (out of window):
  - reg_we is never asserted; bresp=SLVERR.
- awaddr=BaseAddr+0x02 (misaligned):
  - no write; bresp=SLVERR.
- bready held 0 for 5 cycles:
  - bvalid and bresp stay stable;
  - awready=wready=0 throughout;
  - IDLE the cycle after bready=1.
- rst asserted while in WAIT_W:
  - next cycle: IDLE, bvalid=0, awready=wready=1;
  - a subsequent W alone produces no write.

Source files
------------

// File: rtl/axi_reg_pkg.sv
// Shared types for the register-block AXI4-Lite channel controllers.
// Holds the controller state encoding and the B/R response codes.
package axi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    WAIT_A = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/addr_decoder.sv
// Splits a byte address into word offset, byte offset and window-miss flag.
// Purely combinational; no state, no backpressure.
module addr_decoder #(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          OffsetWidth = 6
) (
  input  logic [31:0]            i_addr,
  output logic [OffsetWidth-1:0] o_offset,
  output logic                   o_out_of_range,
  output logic [1:0]             o_byte_offset
);

  // BaseAddr is aligned to the window size, so the upper bits alone decide a hit.
  assign o_out_of_range = (i_addr[31:OffsetWidth+2] != BaseAddr[31:OffsetWidth+2]);
  assign o_offset       = i_addr[OffsetWidth+1:2];
  assign o_byte_offset  = i_addr[1:0];

endmodule

// File: rtl/axi_lite_write_ctrl.sv
// AXI4-Lite write controller: AW/W in either order, one strobed register write, then B.
// Write pulse one cycle after the last of AW/W, bvalid one cycle later; held until bready.
module axi_lite_write_ctrl
  import axi_reg_pkg::*;
#(
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          OffsetWidth = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  output logic                   reg_we,
  output logic [OffsetWidth-1:0] reg_waddr,
  output logic [31:0]            reg_wdata,
  output logic [3:0]             reg_wstrb
);

  state_e      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_strb;
  logic [1:0]  r_bresp;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_out_of_range;
  logic [1:0]             w_byte_offset;
  logic [OffsetWidth-1:0] w_offset;
  logic                   w_addr_ok;

  addr_decoder #(
    .BaseAddr    (BaseAddr),
    .OffsetWidth (OffsetWidth)
  ) u_addr_decoder (
    .i_addr         (r_addr),
    .o_offset       (w_offset),
    .o_out_of_range (w_out_of_range),
    .o_byte_offset  (w_byte_offset)
  );

  assign w_addr_ok = !w_out_of_range && (w_byte_offset == 2'b00);

  // Readies depend on state only, so no valid-to-ready combinational path exists.
  assign awready = (r_state == IDLE) || (r_state == WAIT_A);
  assign wready  = (r_state == IDLE) || (r_state == WAIT_W);
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_strb  <= 4'd0;
      r_bresp <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_addr <= awaddr;
      end
      if (w_w_hs) begin
        r_data <= wdata;
        r_strb <= wstrb;
      end
      case (r_state)
        IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_state <= WRITE;
          end else if (w_aw_hs) begin
            r_state <= WAIT_W;
          end else if (w_w_hs) begin
            r_state <= WAIT_A;
          end
        end
        WAIT_W: begin
          if (w_w_hs) begin
            r_state <= WRITE;
          end
        end
        WAIT_A: begin
          if (w_aw_hs) begin
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_bresp <= w_addr_ok ? RESP_OKAY : RESP_SLVERR;
          r_state <= RESP;
        end
        RESP: begin
          if (bready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign reg_we    = (r_state == WRITE) && w_addr_ok;
  assign reg_waddr = w_offset;
  assign reg_wdata = r_data;
  assign reg_wstrb = r_strb;
  assign bvalid    = (r_state == RESP);
  assign bresp     = r_bresp;

endmodule

// File: tb/tb_axi_lite_write_ctrl.sv
// Directed and randomized check of axi_lite_write_ctrl against a transaction-level model.
// The model tracks which halves of the write are held and where the transaction stands.
module tb_axi_lite_write_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          OW   = 6;
  localparam int unsigned WIN  = 4 * (1 << OW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   awaddr = 32'd0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [31:0]   wdata = 32'd0;
  logic [3:0]    wstrb = 4'd0;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [1:0]    bresp;
  logic          reg_we;
  logic [OW-1:0] reg_waddr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_wstrb;

  int total = 0;
  int bad   = 0;

  axi_lite_write_ctrl #(.BaseAddr(BASE), .OffsetWidth(OW)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    int unsigned off;
    if (a < BASE) return 1'b0;
    off = a - BASE;
    return (off < WIN) && (off % 4 == 0);
  endfunction

  // Transaction-level model: stage 0 collects AW/W, 1 is the write cycle, 2 awaits bready.
  bit          armed = 1'b0;
  int          m_stage = 0;
  bit          m_aw = 1'b0;
  bit          m_w = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_data = 32'd0;
  logic [3:0]  m_strb = 4'd0;
  int          m_writes = 0;

  always @(posedge clk) begin
    if (rst) begin
      armed   = 1'b1;
      m_stage = 0;
      m_aw    = 1'b0;
      m_w     = 1'b0;
    end else if (m_stage == 0) begin
      if (awvalid && !m_aw) begin
        m_aw   = 1'b1;
        m_addr = awaddr;
      end
      if (wvalid && !m_w) begin
        m_w    = 1'b1;
        m_data = wdata;
        m_strb = wstrb;
      end
      if (m_aw && m_w) m_stage = 1;
    end else if (m_stage == 1) begin
      if (addr_ok(m_addr)) m_writes++;
      m_stage = 2;
    end else if (bready) begin
      m_stage = 0;
      m_aw    = 1'b0;
      m_w     = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("awready", 32'(awready), 32'(m_stage == 0 && !m_aw));
      chk("wready",  32'(wready),  32'(m_stage == 0 && !m_w));
      chk("reg_we",  32'(reg_we),  32'(m_stage == 1 && addr_ok(m_addr)));
      chk("bvalid",  32'(bvalid),  32'(m_stage == 2));
      if (m_stage == 1 && addr_ok(m_addr)) begin
        chk("reg_waddr", 32'(reg_waddr), (m_addr - BASE) / 4);
        chk("reg_wdata", reg_wdata, m_data);
        chk("reg_wstrb", 32'(reg_wstrb), 32'(m_strb));
      end
      if (m_stage == 2) begin
        chk("bresp", 32'(bresp), addr_ok(m_addr) ? 32'd0 : 32'd2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  // Both channels in one cycle, then expect the literal write and response.
  task automatic both_same_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input logic exp_we, input logic [1:0] exp_resp, input string nm);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    step();
    idle_inputs();
    @(negedge clk);
    chk({nm, "_we"}, 32'(reg_we), 32'(exp_we));
    step();
    @(negedge clk);
    chk({nm, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({nm, "_bresp"}, 32'(bresp), 32'(exp_resp));
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_reg_we",  32'(reg_we),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    step();

    // Same-cycle AW+W at offset 0x0C.
    awvalid = 1'b1; awaddr = BASE + 32'h0C; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    step();
    idle_inputs();
    @(negedge clk);
    chk("t1_we",    32'(reg_we),    32'd1);
    chk("t1_waddr", 32'(reg_waddr), 32'd3);
    chk("t1_wdata", reg_wdata,      32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk("t1_bvalid", 32'(bvalid), 32'd1);
    chk("t1_bresp",  32'(bresp),  32'd0);
    step();

    // W first, AW three cycles later.
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'b0101;
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_wready_wait", 32'(wready), 32'd0);
      chk("t2_awready_wait", 32'(awready), 32'd1);
      step();
    end
    awvalid = 1'b1; awaddr = BASE + 32'h04;
    step();
    awvalid = 1'b0;
    @(negedge clk);
    chk("t2_we",    32'(reg_we),    32'd1);
    chk("t2_waddr", 32'(reg_waddr), 32'd1);
    chk("t2_wstrb", 32'(reg_wstrb), 32'b0101);
    step();
    @(negedge clk);
    chk("t2_bresp", 32'(bresp), 32'd0);
    step();

    both_same_cycle(BASE + WIN, 32'hAAAA_5555, 4'hF, 1'b0, 2'b10, "t3_oow");
    both_same_cycle(BASE + 32'h02, 32'h5555_AAAA, 4'hF, 1'b0, 2'b10, "t4_misal");
    both_same_cycle(BASE + 32'h10, 32'h0, 4'h0, 1'b1, 2'b00, "t4b_zstrb");

    // Response stalled for five cycles.
    bready = 1'b0;
    awvalid = 1'b1; awaddr = BASE + 32'hFC; wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hC;
    step();
    idle_inputs();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_bvalid",  32'(bvalid),  32'd1);
      chk("t5_bresp",   32'(bresp),   32'd0);
      chk("t5_awready", 32'(awready), 32'd0);
      chk("t5_wready",  32'(wready),  32'd0);
      step();
    end
    bready = 1'b1;
    step();
    @(negedge clk);
    chk("t5_idle_awready", 32'(awready), 32'd1);
    chk("t5_idle_bvalid",  32'(bvalid),  32'd0);
    step();

    // Reset while waiting for W drops the transaction.
    awvalid = 1'b1; awaddr = BASE + 32'h08;
    step();
    awvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_awready", 32'(awready), 32'd1);
    chk("t6_wready",  32'(wready),  32'd1);
    chk("t6_bvalid",  32'(bvalid),  32'd0);
    step();
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_we",     32'(reg_we), 32'd0);
      chk("t6_no_bvalid", 32'(bvalid), 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 4000; i++) begin
      awvalid = 1'($urandom_range(0, 1));
      wvalid  = 1'($urandom_range(0, 1));
      bready  = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 149) == 0);
      wdata   = $urandom;
      wstrb   = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1:    awaddr = BASE + 32'($urandom_range(0, 63) * 4);
        2:       awaddr = BASE + 32'($urandom_range(0, 255));
        default: awaddr = $urandom;
      endcase
      step();
    end
    idle_inputs();
    rst = 1'b0;
    bready = 1'b1;
    repeat (4) step();
    chk("random_writes_seen", 32'(m_writes > 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
